// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32 pipelined core.
// Single outstanding imem request; supports stall (hold) and redirect (flush + refetch).
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] target_q, target_d;

  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus4;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign pc_plus4     = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    buf_d    = buf_q;
    target_d = target_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          id_pc_d = 32'd0;
          if (imem_valid) begin
            // Response for the old path completes now; drop it and refetch at once.
            pc_d = redirect_tgt;
          end else begin
            target_d = redirect_tgt;
            state_d  = DISCARD;
          end
        end else if (imem_valid && !stall) begin
          instr_d = imem_rdata;
          id_pc_d = pc_q;
          pc_d    = pc_plus4;
        end else if (imem_valid && stall) begin
          buf_d   = imem_rdata;
          state_d = HOLD;
        end else if (!stall) begin
          instr_d = NOP_INSTR;
        end
      end

      HOLD: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          id_pc_d = 32'd0;
          pc_d    = redirect_tgt;
          buf_d   = 32'd0;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d = buf_q;
          id_pc_d = pc_q;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end

      DISCARD: begin
        // pc still addresses the in-flight request until its response is swallowed.
        if (redirect) begin
          target_d = redirect_tgt;
          instr_d  = NOP_INSTR;
          id_pc_d  = 32'd0;
        end
        if (imem_valid) begin
          pc_d    = redirect ? redirect_tgt : target_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      id_pc_q  <= 32'd0;
      buf_q    <= 32'd0;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      buf_q    <= buf_d;
      target_q <= target_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_addr   = pc_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_pc    = id_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, zero-wait stream, stall/HOLD, delayed redirect,
// redirect+stall priority, PC wrap (second instance) and async reset mid-HOLD.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  logic        stall2;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_valid2;
  logic [31:0] imem_rdata2;
  logic [31:0] if_id_instr2;
  logic [31:0] if_id_pc2;

  int n_cmp  = 0;
  int n_fail = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .IF_ID_instr(if_id_instr), .IF_ID_pc(if_id_pc)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_valid(imem_valid2),
    .imem_rdata(imem_rdata2), .IF_ID_instr(if_id_instr2), .IF_ID_pc(if_id_pc2)
  );

  // Memory responders: word at address a is 0xA000_0000 | a.
  always_comb begin
    imem_valid  = imem_req && valid_en;
    imem_rdata  = 32'hA000_0000 | imem_addr;
    imem_valid2 = imem_req2;
    imem_rdata2 = 32'hA000_0000 | imem_addr2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("check %-14s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; valid_en = 1'b1;
    stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'd0;
    step; step;
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst2_addr", imem_addr2, 32'hFFFF_FFFC);

    rst = 1'b0;
    step;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);

    step;
    chk("A_instr", if_id_instr, 32'hA000_0000);
    chk("A_pc", if_id_pc, 32'h0);
    chk("wrap_addr1", imem_addr2, 32'h0);
    chk("wrap_idpc", if_id_pc2, 32'hFFFF_FFFC);
    step;
    chk("B_instr", if_id_instr, 32'hA000_0004);
    chk("B_pc", if_id_pc, 32'h4);

    // C returns while stalled for two cycles.
    stall = 1'b1;
    step;
    chk("hold1_instr", if_id_instr, 32'hA000_0004);
    chk("hold1_req", {31'd0, imem_req}, 32'd0);
    step;
    chk("hold2_instr", if_id_instr, 32'hA000_0004);
    chk("hold2_pc", if_id_pc, 32'h4);
    chk("hold2_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    step;
    chk("C_instr", if_id_instr, 32'hA000_0008);
    chk("C_pc", if_id_pc, 32'h8);
    chk("next_addr", imem_addr, 32'hC);
    chk("next_req", {31'd0, imem_req}, 32'd1);

    // Redirect with the response delayed; low address bits must be ignored.
    valid_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h101;
    step;
    redirect = 1'b0;
    chk("rd_flush", if_id_instr, NOP);
    chk("rd_flush_pc", if_id_pc, 32'h0);
    chk("disc_addr", imem_addr, 32'hC);
    chk("disc_req", {31'd0, imem_req}, 32'd1);
    step;
    chk("disc_nop1", if_id_instr, NOP);
    step;
    chk("disc_nop2", if_id_instr, NOP);
    valid_en = 1'b1;
    step;
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_nop3", if_id_instr, NOP);
    step;
    chk("rd_instr", if_id_instr, 32'hA000_0100);
    chk("rd_pc", if_id_pc, 32'h100);

    // Redirect and stall together in FETCH: flush wins.
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h200;
    step;
    redirect = 1'b0; stall = 1'b0;
    chk("fs_flush", if_id_instr, NOP);
    chk("fs_addr", imem_addr, 32'h200);
    step;
    chk("fs_instr", if_id_instr, 32'hA000_0200);
    chk("fs_pc", if_id_pc, 32'h200);

    // Redirect and stall together in HOLD: buffered word must be dropped.
    stall = 1'b1;
    step;
    chk("hs_hold", if_id_instr, 32'hA000_0200);
    redirect = 1'b1; redirect_pc = 32'h300;
    step;
    redirect = 1'b0; stall = 1'b0;
    chk("hs_flush", if_id_instr, NOP);
    chk("hs_flush_pc", if_id_pc, 32'h0);
    chk("hs_addr", imem_addr, 32'h300);
    step;
    chk("hs_instr", if_id_instr, 32'hA000_0300);
    chk("hs_pc", if_id_pc, 32'h300);

    // Async reset pulse in the middle of HOLD.
    stall = 1'b1;
    step;
    chk("ar_hold_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("ar_instr", if_id_instr, NOP);
    chk("ar_pc", if_id_pc, 32'h0);
    chk("ar_addr", imem_addr, 32'h0);
    #1;
    rst = 1'b0; stall = 1'b0;
    step;
    chk("ar_req", {31'd0, imem_req}, 32'd1);
    chk("ar_addr2", imem_addr, 32'h0);
    step;
    chk("ar_instr2", if_id_instr, 32'hA000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
